ocra1_iface: RTL and testbench
==============================

OCRA1_IFACE -- requirements
Module: ocra1_iface

Interface
REQ-001 Parameters: none; all timing below is fixed.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 datax_i  input  24  frame word for X-channel DAC; sampled only when accepted.
REQ-005 datay_i  input  24  frame word for Y-channel DAC.
REQ-006 dataz_i  input  24  frame word for Z-channel DAC.
REQ-007 dataz2_i  input  24  frame word for Z2-channel DAC.
REQ-008 valid_i  input  1  one-cycle request to transmit the four words.
REQ-009 busy_o  output  1  high while a transfer is in progress.
REQ-010 oc1_clk_o  output  1  serial clock shared by all four DACs.
REQ-011 oc1_syncn_o  output  1  active-low frame sync shared by all four DACs.
REQ-012 oc1_ldacn_o  output  1  active-low DAC load strobe shared by all four DACs.
REQ-013 oc1_sdox_o, oc1_sdoy_o, oc1_sdoz_o, oc1_sdoz2_o  output  1 each  per-channel serial data.

Function
REQ-014 Words SHALL be transmitted verbatim, with no formatting: bit 23 (R/W), bits 22:20 (address), bits 19:0 (data/control) are the caller's responsibility.
REQ-015 The FSM SHALL have states IDLE, SHIFT, SYNC_HI, LDAC.
REQ-016 In IDLE, a rising edge with valid_i=1 SHALL latch all four words into 24-bit shift registers, enter SHIFT, and assert busy_o from the next cycle.
REQ-017 valid_i while busy_o=1 SHALL be ignored; input words SHALL NOT be resampled during a transfer.
REQ-018 In SHIFT, oc1_syncn_o=0, and each bit SHALL occupy 2 clk cycles, MSB (bit 23) first:
 - phase A: oc1_clk_o=1, sdo lines driving the current bit;
 - phase B: oc1_clk_o=0, the DAC samples on this falling edge.
REQ-019 Sdo lines SHALL change only at the start of phase A, so data is stable around each falling oc1_clk_o edge.
REQ-020 SHIFT SHALL last exactly 48 cycles (24 bits), then enter SYNC_HI.
REQ-021 SYNC_HI SHALL last 1 cycle: oc1_syncn_o=1, oc1_clk_o=1, sdo lines 0.
REQ-022 LDAC SHALL last 1 cycle with oc1_ldacn_o=0, then return to IDLE with busy_o=0.
REQ-023 busy_o SHALL be high for exactly 50 cycles per transfer.
REQ-024 The next valid_i SHALL be accepted on the first cycle busy_o=0.
REQ-025 In IDLE: oc1_clk_o=1, oc1_syncn_o=1, oc1_ldacn_o=1, sdo lines 0.
REQ-026 All outputs SHALL be registered (glitch-free).
REQ-027 The four channels SHALL shift in lockstep; each channel's sdo SHALL be independent of the other channels' data.

Reset
REQ-028 resetn=0 SHALL immediately (asynchronously) force:
 - state IDLE, busy_o=0;
 - oc1_clk_o=1, oc1_syncn_o=1, oc1_ldacn_o=1;
 - all sdo lines 0, shift registers and bit counter 0.
REQ-029 Reset asserted mid-transfer SHALL abort the frame: syncn rises without an LDAC pulse, so the DAC output registers are not updated.
REQ-030 After resetn rises, the first accepted valid_i SHALL start a complete, fresh frame.

Verification
REQ-031 Bench connects four AD5781 behavioural models (sdin←sdo*, sclk←oc1_clk_o, syncn, ldacn shared, clrn=resetn=1) and covers these scenarios:
 - valid_i pulse with X=0x000001, Y=0x000002, Z=0x000003, Z2=0x000004 -> each model receives the corresponding 24-bit word MSB first; one LDAC low pulse; busy_o high 50 cycles.
 - X=0x100005, Y=0x100006, Z=0x100007, Z2=0x100008 (DAC-register writes) -> after LDAC, model outputs X=1, Y=1, Z=1, Z2=2 (data bits 19:2).
 - Second valid_i 10 cycles into a transfer -> ignored; the frame completes with the first words unchanged.
 - Back-to-back requests, second valid_i on the first idle cycle -> two complete 50-cycle transfers, no gap violations.
 - resetn low at bit 12 -> outputs go to idle values immediately; no LDAC pulse; DAC outputs unchanged.
 - 0xFFFFFF and 0x000000 on alternating channels -> sdo lines are constant 1/0 throughout SHIFT; no cross-talk between channels.

Source files
------------

// File: rtl/ocra1_iface.sv
// rtl/ocra1_iface.sv - four-channel lockstep serial frame transmitter for AD5781-style DACs
//
// Purpose:
//   Accepts four 24-bit frame words on a one-cycle valid_i request and shifts
//   them out MSB first on four independent data lines that share one serial
//   clock, frame sync and LDAC strobe. Words are sent verbatim; the caller
//   builds the R/W bit, register address and data field.
//
// Frame timing (busy_o high for 50 cycles):
//   SHIFT   48 cycles : 24 bits x 2 phases (A: sclk=1, new bit; B: sclk=0, DAC samples)
//   SYNC_HI  1 cycle  : syncn=1, sclk=1, sdo=0
//   LDAC     1 cycle  : ldacn=0
//
// Ports:
//   clk          system clock, all state changes on rising edge
//   resetn       asynchronous active-low reset, aborts any frame in flight
//   datax_i      X-channel frame word, sampled only on acceptance
//   datay_i      Y-channel frame word
//   dataz_i      Z-channel frame word
//   dataz2_i     Z2-channel frame word
//   valid_i      one-cycle transmit request, ignored while busy
//   busy_o       transfer in progress
//   oc1_clk_o    shared serial clock (idles high)
//   oc1_syncn_o  shared active-low frame sync
//   oc1_ldacn_o  shared active-low DAC load strobe
//   oc1_sdo*_o   per-channel serial data

module ocra1_iface (
    input  logic        clk,
    input  logic        resetn,
    input  logic [23:0] datax_i,
    input  logic [23:0] datay_i,
    input  logic [23:0] dataz_i,
    input  logic [23:0] dataz2_i,
    input  logic        valid_i,
    output logic        busy_o,
    output logic        oc1_clk_o,
    output logic        oc1_syncn_o,
    output logic        oc1_ldacn_o,
    output logic        oc1_sdox_o,
    output logic        oc1_sdoy_o,
    output logic        oc1_sdoz_o,
    output logic        oc1_sdoz2_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        SYNC_HI = 2'd2,
        LDAC    = 2'd3
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'd23;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;       // 0 = phase A (sclk high), 1 = phase B (sclk low)
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] shx_q, shx_d;
    logic [23:0] shy_q, shy_d;
    logic [23:0] shz_q, shz_d;
    logic [23:0] shz2_q, shz2_d;

    // Registered outputs
    logic        busy_q, busy_d;
    logic        sclk_q, sclk_d;
    logic        syncn_q, syncn_d;
    logic        ldacn_q, ldacn_d;
    logic [3:0]  sdo_q, sdo_d;           // {z2, z, y, x}

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so that the registered pins line up with that state.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shx_d     = shx_q;
        shy_d     = shy_q;
        shz_d     = shz_q;
        shz2_d    = shz2_q;
        busy_d    = busy_q;
        sclk_d    = sclk_q;
        syncn_d   = syncn_q;
        ldacn_d   = ldacn_q;
        sdo_d     = sdo_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_d   = SHIFT;
                    phase_d   = 1'b0;
                    bit_cnt_d = 5'd0;
                    shx_d     = datax_i;
                    shy_d     = datay_i;
                    shz_d     = dataz_i;
                    shz2_d    = dataz2_i;
                    busy_d    = 1'b1;
                    sclk_d    = 1'b1;
                    syncn_d   = 1'b0;
                    ldacn_d   = 1'b1;
                    // First bit goes out together with the falling sync
                    sdo_d     = {dataz2_i[23], dataz_i[23], datay_i[23], datax_i[23]};
                end
            end

            SHIFT: begin
                if (!phase_q) begin
                    // Phase A -> B: drop sclk, hold data so it is stable at the DAC sampling edge
                    phase_d = 1'b1;
                    sclk_d  = 1'b0;
                end else if (bit_cnt_q == LAST_BIT) begin
                    state_d = SYNC_HI;
                    phase_d = 1'b0;
                    sclk_d  = 1'b1;
                    syncn_d = 1'b1;
                    sdo_d   = 4'b0000;
                end else begin
                    // Phase B -> A of the next bit: advance shifters, present next bit
                    phase_d   = 1'b0;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    shx_d     = {shx_q[22:0], 1'b0};
                    shy_d     = {shy_q[22:0], 1'b0};
                    shz_d     = {shz_q[22:0], 1'b0};
                    shz2_d    = {shz2_q[22:0], 1'b0};
                    sclk_d    = 1'b1;
                    sdo_d     = {shz2_q[22], shz_q[22], shy_q[22], shx_q[22]};
                end
            end

            SYNC_HI: begin
                state_d = LDAC;
                ldacn_d = 1'b0;
            end

            LDAC: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                ldacn_d   = 1'b1;
                bit_cnt_d = 5'd0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sclk_d  = 1'b1;
                syncn_d = 1'b1;
                ldacn_d = 1'b1;
                sdo_d   = 4'b0000;
            end
        endcase
    end

    // Reset forces idle pin levels at once; an aborted frame therefore ends
    // with syncn rising and no LDAC pulse, leaving the DAC outputs untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            phase_q   <= 1'b0;
            bit_cnt_q <= 5'd0;
            shx_q     <= 24'd0;
            shy_q     <= 24'd0;
            shz_q     <= 24'd0;
            shz2_q    <= 24'd0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b1;
            syncn_q   <= 1'b1;
            ldacn_q   <= 1'b1;
            sdo_q     <= 4'b0000;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shx_q     <= shx_d;
            shy_q     <= shy_d;
            shz_q     <= shz_d;
            shz2_q    <= shz2_d;
            busy_q    <= busy_d;
            sclk_q    <= sclk_d;
            syncn_q   <= syncn_d;
            ldacn_q   <= ldacn_d;
            sdo_q     <= sdo_d;
        end
    end

    assign busy_o      = busy_q;
    assign oc1_clk_o   = sclk_q;
    assign oc1_syncn_o = syncn_q;
    assign oc1_ldacn_o = ldacn_q;
    assign oc1_sdox_o  = sdo_q[0];
    assign oc1_sdoy_o  = sdo_q[1];
    assign oc1_sdoz_o  = sdo_q[2];
    assign oc1_sdoz2_o = sdo_q[3];

endmodule

// File: tb/tb_ocra1_iface.sv
// tb/tb_ocra1_iface.sv - directed bench for ocra1_iface with four AD5781-style receiver models
module tb_ocra1_iface;

    logic        clk = 1'b0;
    logic        resetn;
    logic [23:0] datax_i, datay_i, dataz_i, dataz2_i;
    logic        valid_i;
    logic        busy_o;
    logic        oc1_clk_o, oc1_syncn_o, oc1_ldacn_o;
    logic        oc1_sdox_o, oc1_sdoy_o, oc1_sdoz_o, oc1_sdoz2_o;
    logic [3:0]  sdo_vec;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ocra1_iface dut (
        .clk         (clk),
        .resetn      (resetn),
        .datax_i     (datax_i),
        .datay_i     (datay_i),
        .dataz_i     (dataz_i),
        .dataz2_i    (dataz2_i),
        .valid_i     (valid_i),
        .busy_o      (busy_o),
        .oc1_clk_o   (oc1_clk_o),
        .oc1_syncn_o (oc1_syncn_o),
        .oc1_ldacn_o (oc1_ldacn_o),
        .oc1_sdox_o  (oc1_sdox_o),
        .oc1_sdoy_o  (oc1_sdoy_o),
        .oc1_sdoz_o  (oc1_sdoz_o),
        .oc1_sdoz2_o (oc1_sdoz2_o)
    );

    assign sdo_vec = {oc1_sdoz2_o, oc1_sdoz_o, oc1_sdoy_o, oc1_sdox_o};

    // AD5781 behavioural receivers (channel order x, y, z, z2)
    logic [23:0] rx_sr   [4];
    logic [23:0] rx_word [4];
    logic [19:0] dac_in  [4];
    logic [17:0] dac_out [4];
    int          rx_cnt    = 0;
    int          frame_cnt = 0;
    int          ldac_cnt  = 0;

    initial begin
        for (int ch = 0; ch < 4; ch++) begin
            rx_sr[ch]   = 24'd0;
            rx_word[ch] = 24'd0;
            dac_in[ch]  = 20'd0;
            dac_out[ch] = 18'd0;
        end
    end

    always @(negedge oc1_syncn_o) rx_cnt = 0;

    always @(negedge oc1_clk_o) begin
        if (!oc1_syncn_o) begin
            for (int ch = 0; ch < 4; ch++) rx_sr[ch] = {rx_sr[ch][22:0], sdo_vec[ch]};
            rx_cnt++;
        end
    end

    // Only a complete 24-bit frame is accepted; DAC register is address 1 with R/W=0
    always @(posedge oc1_syncn_o) begin
        if (rx_cnt == 24) begin
            frame_cnt++;
            for (int ch = 0; ch < 4; ch++) begin
                rx_word[ch] = rx_sr[ch];
                if (!rx_sr[ch][23] && rx_sr[ch][22:20] == 3'd1) dac_in[ch] = rx_sr[ch][19:0];
            end
        end
        rx_cnt = 0;
    end

    always @(negedge oc1_ldacn_o) begin
        ldac_cnt++;
        for (int ch = 0; ch < 4; ch++) dac_out[ch] = dac_in[ch][19:2];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [3:0] sdo_and, sdo_or;

    // Called at a falling clk edge; requests a frame on the following rising edge.
    task automatic send_frame(input logic [23:0] x, input logic [23:0] y,
                              input logic [23:0] z, input logic [23:0] z2,
                              input int mid_at, input int abort_at, input string tag);
        int idx;
        datax_i = x; datay_i = y; dataz_i = z; dataz2_i = z2;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        check_eq({tag, "_busy_start"}, busy_o, 1'b1);
        check_eq({tag, "_first_bit"}, {oc1_clk_o, oc1_syncn_o, oc1_sdox_o}, {1'b1, 1'b0, x[23]});
        sdo_and = 4'hF;
        sdo_or  = 4'h0;
        idx = 0;
        while (busy_o && idx < 100) begin
            if (idx == mid_at) begin
                datax_i = 24'hABCDEF; datay_i = 24'hABCDEF;
                dataz_i = 24'hABCDEF; dataz2_i = 24'hABCDEF;
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            if (idx == abort_at) begin
                resetn = 1'b0;
                #1;
                check_eq({tag, "_abort_pins"},
                         {busy_o, oc1_clk_o, oc1_syncn_o, oc1_ldacn_o, sdo_vec},
                         {1'b0, 1'b1, 1'b1, 1'b1, 4'b0000});
                @(negedge clk);
                @(negedge clk);
                resetn = 1'b1;
                break;
            end
            if (!oc1_syncn_o) begin
                sdo_and = sdo_and & sdo_vec;
                sdo_or  = sdo_or | sdo_vec;
            end
            idx++;
            @(negedge clk);
        end
        valid_i = 1'b0;
        if (abort_at < 0) check_eq({tag, "_busy_len"}, idx, 50);
    endtask

    int f0, l0;

    initial begin
        resetn   = 1'b0;
        valid_i  = 1'b0;
        datax_i  = 24'd0; datay_i = 24'd0; dataz_i = 24'd0; dataz2_i = 24'd0;
        #23;
        check_eq("reset_pins", {busy_o, oc1_clk_o, oc1_syncn_o, oc1_ldacn_o, sdo_vec},
                 {1'b0, 1'b1, 1'b1, 1'b1, 4'b0000});
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("idle_pins", {busy_o, oc1_clk_o, oc1_syncn_o, oc1_ldacn_o, sdo_vec},
                 {1'b0, 1'b1, 1'b1, 1'b1, 4'b0000});

        // 1: plain words, no DAC register write
        f0 = frame_cnt; l0 = ldac_cnt;
        send_frame(24'h000001, 24'h000002, 24'h000003, 24'h000004, -1, -1, "f1");
        check_eq("f1_rx_x", rx_word[0], 24'h000001);
        check_eq("f1_rx_y", rx_word[1], 24'h000002);
        check_eq("f1_rx_z", rx_word[2], 24'h000003);
        check_eq("f1_rx_z2", rx_word[3], 24'h000004);
        check_eq("f1_frames", frame_cnt - f0, 1);
        check_eq("f1_ldac", ldac_cnt - l0, 1);
        check_eq("f1_dac_x", dac_out[0], 18'd0);

        // 2: DAC register writes
        @(negedge clk);
        send_frame(24'h100005, 24'h100006, 24'h100007, 24'h100008, -1, -1, "f2");
        check_eq("f2_dac_x", dac_out[0], 18'd1);
        check_eq("f2_dac_y", dac_out[1], 18'd1);
        check_eq("f2_dac_z", dac_out[2], 18'd1);
        check_eq("f2_dac_z2", dac_out[3], 18'd2);

        // 3: second request 10 cycles in must be ignored
        @(negedge clk);
        f0 = frame_cnt; l0 = ldac_cnt;
        send_frame(24'h100011, 24'h100021, 24'h100031, 24'h100041, 10, -1, "f3");
        check_eq("f3_rx_x", rx_word[0], 24'h100011);
        check_eq("f3_rx_z2", rx_word[3], 24'h100041);
        check_eq("f3_dac", {dac_out[0], dac_out[1], dac_out[2], dac_out[3]},
                 {18'd4, 18'd8, 18'd12, 18'd16});
        repeat (3) @(negedge clk);
        check_eq("f3_no_second", busy_o, 1'b0);
        check_eq("f3_frames", frame_cnt - f0, 1);
        check_eq("f3_ldac", ldac_cnt - l0, 1);

        // 4: back-to-back, second request on the first idle cycle
        f0 = frame_cnt; l0 = ldac_cnt;
        send_frame(24'h100100, 24'h100101, 24'h100102, 24'h100103, -1, -1, "b2b_a");
        check_eq("b2b_a_rx_y", rx_word[1], 24'h100101);
        send_frame(24'h100200, 24'h100300, 24'h100400, 24'h100500, -1, -1, "b2b_b");
        check_eq("b2b_frames", frame_cnt - f0, 2);
        check_eq("b2b_ldac", ldac_cnt - l0, 2);
        check_eq("b2b_dac", {dac_out[0], dac_out[1], dac_out[2], dac_out[3]},
                 {18'h80, 18'hC0, 18'h100, 18'h140});

        // 5: reset at bit 12 aborts the frame
        @(negedge clk);
        f0 = frame_cnt; l0 = ldac_cnt;
        send_frame(24'h1FFFFC, 24'h1FFFFC, 24'h1FFFFC, 24'h1FFFFC, -1, 24, "rst");
        @(negedge clk);
        check_eq("rst_frames", frame_cnt - f0, 0);
        check_eq("rst_ldac", ldac_cnt - l0, 0);
        check_eq("rst_dac", {dac_out[0], dac_out[1], dac_out[2], dac_out[3]},
                 {18'h80, 18'hC0, 18'h100, 18'h140});
        check_eq("rst_idle_busy", busy_o, 1'b0);
        f0 = frame_cnt;
        send_frame(24'h000007, 24'h000070, 24'h000700, 24'h007000, -1, -1, "fresh");
        check_eq("fresh_rx", {rx_word[0], rx_word[3]}, {24'h000007, 24'h007000});
        check_eq("fresh_frames", frame_cnt - f0, 1);

        // 6: alternating all-ones / all-zeros channels
        @(negedge clk);
        send_frame(24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, -1, -1, "alt");
        check_eq("alt_sdo_and", sdo_and, 4'b0101);
        check_eq("alt_sdo_or", sdo_or, 4'b0101);
        check_eq("alt_rx", {rx_word[0], rx_word[1], rx_word[2], rx_word[3]},
                 {24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000});

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
